// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: fetch PC, single-outstanding imem request,
// small instruction FIFO and redirect/flush handling toward decode.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [5:0]  op,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {S_FETCH, S_DROP} state_e;

  state_e         state_q, state_d;
  logic           req_q, req_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    pc_q, pc_d;
  logic [AW-1:0]  rd_q, rd_d;
  logic [AW-1:0]  wr_q, wr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    inst_q, inst_d;
  logic [31:0]    ipc_q, ipc_d;
  logic [31:0]    word_q [FIFO_DEPTH];
  logic [31:0]    wpc_q  [FIFO_DEPTH];
  logic           nonempty, push, pop;
  logic [31:0]    redir_pc;

  assign nonempty = (cnt_q != '0);
  assign pop      = nonempty & inst_ready;
  assign push     = req_q & imem_ack & (state_q == S_FETCH) & ~redirect & ~rst;
  assign redir_pc = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // A redirect with the request still in flight must swallow its late ack.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: if (redirect && req_q && !imem_ack) state_d = S_DROP;
      S_DROP:  if (imem_ack) state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect)  pc_d = redir_pc;
    else if (push) pc_d = addr_q + 32'd4;

    if (redirect) begin
      cnt_d = '0;
      rd_d  = wr_q;
      wr_d  = wr_q;
    end else begin
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      rd_d  = rd_q + AW'(pop);
      wr_d  = wr_q + AW'(push);
    end

    if (req_q && !imem_ack) begin
      req_d  = 1'b1;
      addr_d = addr_q;
    end else begin
      req_d  = (cnt_d < CW'(FIFO_DEPTH));
      addr_d = pc_d;
    end

    // Head registers follow the next FIFO head; they hold when it empties.
    inst_d = inst_q;
    ipc_d  = ipc_q;
    if (cnt_d != '0) begin
      if (push && wr_q == rd_d) begin
        inst_d = imem_rdata;
        ipc_d  = addr_q;
      end else begin
        inst_d = word_q[rd_d];
        ipc_d  = wpc_q[rd_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q  <= 1'b0;
      addr_q <= RESET_PC;
      pc_q   <= RESET_PC;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      inst_q <= '0;
      ipc_q  <= '0;
    end else begin
      req_q  <= req_d;
      addr_q <= addr_d;
      pc_q   <= pc_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      inst_q <= inst_d;
      ipc_q  <= ipc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      word_q[wr_q] <= imem_rdata;
      wpc_q[wr_q]  <= addr_q;
    end
  end

  always_comb begin
    imem_req   = req_q;
    imem_addr  = addr_q;
    inst_valid = nonempty;
    inst       = inst_q;
    inst_pc    = ipc_q;
    op         = inst_q[31:26];
  end

  ovf_a: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && cnt_q == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios plus a randomized run
// checked against an abstract in-order instruction stream model.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_ack, inst_valid, inst_ready, redirect;
  logic [31:0] imem_addr, imem_rdata, inst, inst_pc, redirect_pc;
  logic [5:0]  op;
  logic [31:0] w;
  int          total = 0;
  int          passed = 0;

  inst_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .op(op),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] a);
    return 32'h8C08_0004 ^ (a * 32'h0410_0001);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    imem_rdata = f(imem_addr);
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b1; inst_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    imem_rdata = f(32'h0);
    step(); step();
    total++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0)
      $display("FAIL reset_req req=%0b addr=%h want 0/0", imem_req, imem_addr);
    else passed++;
    total++;
    if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 || op !== 6'h0)
      $display("FAIL reset_out v=%0b inst=%h pc=%h op=%h want zeros",
               inst_valid, inst, inst_pc, op);
    else passed++;
  endtask

  task automatic test_stream();
    rst = 1'b0; imem_ack = 1'b1; inst_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4*k))
        $display("FAIL stream_addr k=%0d req=%0b addr=%h want %h",
                 k, imem_req, imem_addr, 32'(4*k));
      else passed++;
      if (k == 0) begin
        total++;
        if (inst_valid !== 1'b0)
          $display("FAIL stream_first_valid got %0b want 0", inst_valid);
        else passed++;
      end else begin
        w = f(32'(4*(k-1)));
        total++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'(4*(k-1)) ||
            inst !== w || op !== w[31:26])
          $display("FAIL stream_inst k=%0d v=%0b pc=%h inst=%h op=%h want pc=%h inst=%h",
                   k, inst_valid, inst_pc, inst, op, 32'(4*(k-1)), w);
        else passed++;
      end
      if (k == 1) begin
        total++;
        if (op !== 6'b100011)
          $display("FAIL stream_op got %b want 100011", op);
        else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    inst_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      total++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b1 ||
          inst_pc !== 32'h18 || inst !== f(32'h18))
        $display("FAIL stall k=%0d req=%0b v=%0b pc=%h inst=%h want req=0 pc=18",
                 k, imem_req, inst_valid, inst_pc, inst);
      else passed++;
    end
    inst_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      total++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'(32'h18 + 4*k) ||
          inst !== f(32'(32'h18 + 4*k)))
        $display("FAIL drain k=%0d v=%0b pc=%h want %h",
                 k, inst_valid, inst_pc, 32'(32'h18 + 4*k));
      else passed++;
      step();
    end
  endtask

  task automatic test_drop();
    imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'h10;
    step();
    redirect = 1'b0;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10 || inst_valid !== 1'b0)
      $display("FAIL drop_setup req=%0b addr=%h v=%0b want 1/10/0",
               imem_req, imem_addr, inst_valid);
    else passed++;
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h10 || inst_valid !== 1'b0)
        $display("FAIL drop_hold k=%0d req=%0b addr=%h v=%0b want 1/10/0",
                 k, imem_req, imem_addr, inst_valid);
      else passed++;
      if (k < 2) step();
    end
    imem_ack = 1'b1;
    step();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40 || inst_valid !== 1'b0)
      $display("FAIL drop_next req=%0b addr=%h v=%0b want 1/40/0",
               imem_req, imem_addr, inst_valid);
    else passed++;
    step();
    total++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst !== f(32'h40))
      $display("FAIL drop_first v=%0b pc=%h inst=%h want pc=40", inst_valid, inst_pc, inst);
    else passed++;
  endtask

  task automatic test_redirect_ack();
    redirect = 1'b1; redirect_pc = 32'h123;
    step();
    redirect = 1'b0;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h120 || inst_valid !== 1'b0)
      $display("FAIL redir_ack req=%0b addr=%h v=%0b want 1/120/0",
               imem_req, imem_addr, inst_valid);
    else passed++;
    step();
    total++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h120 || imem_addr !== 32'h124)
      $display("FAIL redir_first v=%0b pc=%h addr=%h want pc=120 addr=124",
               inst_valid, inst_pc, imem_addr);
    else passed++;
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    total++;
    if (imem_addr !== 32'hFFFF_FFFC || inst_valid !== 1'b0)
      $display("FAIL wrap_a addr=%h v=%0b want fffffffc/0", imem_addr, inst_valid);
    else passed++;
    step();
    total++;
    if (imem_addr !== 32'h0 || inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC)
      $display("FAIL wrap_b addr=%h pc=%h want 0/fffffffc", imem_addr, inst_pc);
    else passed++;
    step();
    total++;
    if (imem_addr !== 32'h4 || inst_pc !== 32'h0 || inst !== f(32'h0))
      $display("FAIL wrap_c addr=%h pc=%h want 4/0", imem_addr, inst_pc);
    else passed++;
  endtask

  task automatic test_reset_mid();
    imem_ack = 1'b0; inst_ready = 1'b0;
    step();
    total++;
    if (imem_req !== 1'b1 || inst_valid !== 1'b1)
      $display("FAIL rmid_pre req=%0b v=%0b want 1/1", imem_req, inst_valid);
    else passed++;
    rst = 1'b1; imem_ack = 1'b1;
    step();
    total++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || inst_valid !== 1'b0 ||
        inst !== 32'h0 || inst_pc !== 32'h0 || op !== 6'h0)
      $display("FAIL rmid_reset req=%0b addr=%h v=%0b inst=%h pc=%h want zeros",
               imem_req, imem_addr, inst_valid, inst, inst_pc);
    else passed++;
    step();
    rst = 1'b0; imem_ack = 1'b0;
    step();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0)
      $display("FAIL rmid_restart req=%0b addr=%h v=%0b want 1/0/0",
               imem_req, imem_addr, inst_valid);
    else passed++;
    imem_ack = 1'b1;
    step();
    total++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== f(32'h0))
      $display("FAIL rmid_first v=%0b pc=%h want 1/0", inst_valid, inst_pc);
    else passed++;
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, prev_addr;
    logic        prev_pend, prev_redir;
    int          xfers;
    exp_pc = 32'h0; prev_pend = 1'b0; prev_redir = 1'b0; prev_addr = '0;
    xfers = 0;
    for (int i = 0; i < 3000; i++) begin
      if (prev_pend) begin
        total++;
        if (imem_req !== 1'b1 || imem_addr !== prev_addr)
          $display("FAIL rnd_hold i=%0d req=%0b addr=%h want 1/%h",
                   i, imem_req, imem_addr, prev_addr);
        else passed++;
      end
      if (prev_redir) begin
        total++;
        if (inst_valid !== 1'b0)
          $display("FAIL rnd_flush i=%0d v=%0b want 0", i, inst_valid);
        else passed++;
      end
      if (imem_req === 1'b1) begin
        total++;
        if (imem_addr[1:0] !== 2'b00)
          $display("FAIL rnd_align i=%0d addr=%h want aligned", i, imem_addr);
        else passed++;
      end
      imem_ack   = ($urandom_range(0, 3) != 0);
      inst_ready = 1'($urandom_range(0, 1));
      redirect   = ($urandom_range(0, 24) == 0);
      redirect_pc = $urandom;
      if ($urandom_range(0, 3) == 0)
        redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      if (inst_valid === 1'b1 && inst_ready) begin
        w = f(exp_pc);
        total++;
        if (inst_pc !== exp_pc || inst !== w || op !== w[31:26])
          $display("FAIL rnd_inst i=%0d pc=%h inst=%h op=%h want pc=%h inst=%h",
                   i, inst_pc, inst, op, exp_pc, w);
        else passed++;
        exp_pc = exp_pc + 32'd4;
        xfers++;
      end
      if (redirect) exp_pc = redirect_pc & 32'hFFFF_FFFC;
      prev_pend  = imem_req && !imem_ack;
      prev_addr  = imem_addr;
      prev_redir = redirect;
      step();
    end
    redirect = 1'b0;
    total++;
    if (xfers <= 300)
      $display("FAIL rnd_progress transfers=%0d want >300", xfers);
    else passed++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_drop();
    test_redirect_ack();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
